// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner arbitrating sequential, jump, branch, call/return and halt,
// with a small return-address stack and run/halt/fault status.
module pc_sequencer #(
  parameter int PW = 9,
  parameter int OW = 8,
  parameter int SD = 4,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  jump_en,
  input  logic                  branch_en,
  input  logic                  call_en,
  input  logic                  ret_en,
  input  logic                  halt_req,
  input  logic [PW-1:0]         target,
  input  logic [OW-1:0]         offset,
  output logic [PW-1:0]         prog_ctr,
  output logic                  redirect,
  output logic                  running,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [$clog2(SD):0]   depth
);
  localparam int AW = $clog2(SD);
  localparam logic [AW:0] FULL = (AW+1)'(SD);
  localparam logic [AW:0] D1 = 1;
  localparam logic [PW-1:0] P1 = 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic redirect_q, redirect_d;
  logic [1:0] fc_q, fc_d;
  logic [AW:0] depth_q, depth_d;
  logic [PW-1:0] stk_q [SD];
  logic [PW-1:0] stk_d [SD];
  logic [PW-1:0] off_ext;
  logic [AW-1:0] top;
  assign off_ext = PW'($signed(offset));
  assign top = AW'(depth_q - D1);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redirect_d = 1'b0;
    fc_d = fc_q;
    depth_d = depth_q;
    stk_d = stk_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      pc_d = PW'(START_ADDR);
    end else if (state_q == RUN && !stall) begin
      if (halt_req) begin
        state_d = HALT;
      end else if (ret_en) begin
        if (depth_q == '0) begin
          state_d = FAULT;
          fc_d = 2'b10;
        end else begin
          pc_d = stk_q[top];
          depth_d = depth_q - D1;
          redirect_d = 1'b1;
        end
      end else if (call_en) begin
        if (depth_q == FULL) begin
          state_d = FAULT;
          fc_d = 2'b01;
        end else begin
          stk_d[depth_q[AW-1:0]] = pc_q + P1;
          pc_d = target;
          depth_d = depth_q + D1;
          redirect_d = 1'b1;
        end
      end else if (jump_en || branch_en) begin
        pc_d = jump_en ? target : pc_q + off_ext;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_q + P1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      redirect_q <= 1'b0;
      fc_q <= 2'b00;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redirect_q <= redirect_d;
      fc_q <= fc_d;
      depth_q <= depth_d;
      stk_q <= stk_d;
    end
  end
  assign prog_ctr = pc_q;
  assign redirect = redirect_q;
  assign running = state_q == RUN;
  assign done = state_q == HALT;
  assign fault = state_q == FAULT;
  assign fault_code = fc_q;
  assign depth = depth_q;
endmodule
